mole_round_sched: RTL and testbench
===================================

# mole_round_sched

Game-session sequencer for the whack-a-mole datapath. It runs each game from start to game-over: it requests a pattern from the pattern generator, shows it for a level-dependent round time and judges button input. It also tracks score, lives, difficulty level and high score. It sits between the pattern generator, the debounced/locked-out button bus and the 7-segment/LED drivers.

## Interface
Parameters:
- ROUND_T0, 5000, round length in cycles at level 0
- ROUND_STEP, 1000, cycles removed per level
- ROUND_MIN, 2000, floor on round length
- LIVES, 3, lives per game (1..3)
- LEVEL_UP, 5, consecutive-in-level hits needed to advance one level (>=1)
- GAP_CYC, 500, minimum blank cycles between rounds (>=1)

Ports:
- clk  in  1  system clock; one clock for the whole block
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  low acts as synchronous reset, except hiscore is retained
- start  in  1  start request; a game starts only on a rising edge
- btn  in  7  synchronized buttons, one per segment
- pat_req  out  1  request for a new pattern
- pat_valid  in  1  pattern generator output valid
- pat_in  in  7  candidate pattern
- mole  out  7  pattern to display; 0 when not showing
- level  out  2  difficulty level 0..3
- num_lit  out  3  level+1; feeds the pattern generator
- score  out  8  hits this game; saturates at 255
- lives  out  2  remaining lives
- hiscore  out  8  best score since rst_n
- game_over  out  1  high in OVER
- busy  out  1  high in REQ, SHOW or GAP

## Operation
- States are IDLE, REQ, SHOW, GAP and OVER. On reset the block enters IDLE with these output values:
  - mole=0, level=0, score=0, lives=0, hiscore=0 (ena low keeps hiscore), pat_req=0, game_over=0, busy=0
  - internal start_q=1
- Start edge is `start & ~start_q`. start_q resets to 1, so a start held through reset does not trigger a game.
- IDLE / OVER: a start edge sets score=0, lives=LIVES, level=0 and hit_cnt=0, then goes to REQ.
- REQ: pat_req=1 (Moore).
  - Handshake occurs when pat_req & pat_valid.
  - If pat_in != 0: mole <= pat_in, round counter <= preset-1, go to SHOW.
  - If pat_in == 0: the pattern is consumed and discarded; stay in REQ.
- preset = max(ROUND_T0 - level*ROUND_STEP, ROUND_MIN). Computed at 16 bits with no underflow; use ROUND_MIN when the subtraction would go negative.
- SHOW: each cycle is evaluated in this priority order.
  1. Wrong press, `(btn & ~mole) != 0`: lose a life.
  2. Hit, `(btn & mole) == mole`: score+1 (saturating) and hit_cnt+1. If hit_cnt reaches LEVEL_UP and level<3, then level+1 and hit_cnt=0. At level 3, hit_cnt saturates. Go to GAP.
  3. Timeout, counter==0: lose a life.
  4. Otherwise: counter-1.
- Lose a life:
  - If lives==1: lives=0, go to OVER.
  - Else: lives-1, go to GAP. level and hit_cnt are unchanged.
- GAP: mole=0. Count GAP_CYC cycles, then additionally wait for btn==0. Then go to REQ.
- OVER: game_over=1, mole=0. On the entry edge, hiscore <= score if score > hiscore. Stay in OVER until a start edge.
- No btn or pat_valid activity outside REQ/SHOW has any effect.

## Timing
- All outputs are registered and change on the clock edge that performs the transition.
- Handshake to display: mole is valid on the cycle after the accepting edge.
- With no input, SHOW lasts exactly preset cycles. The timeout is judged in the last SHOW cycle.
- A hit and a timeout in the same cycle count as a hit.
- A wrong press outranks a hit in the same cycle. A full mole plus an extra bit counts as wrong.
- GAP lasts at least GAP_CYC cycles. It is extended while any btn bit is high.
- pat_req rises the cycle after GAP ends. Minimum REQ→SHOW latency is 1 cycle.
- rst_n or ena low in any state returns the block to IDLE on that edge. An in-flight round is discarded.
- A start edge during REQ, SHOW or GAP is ignored.

## Test plan
The bench uses ROUND_T0=20, ROUND_STEP=5, ROUND_MIN=10, LIVES=3, LEVEL_UP=2, GAP_CYC=4, with pat_valid=1 and pat_in=7'b0000101 unless stated.
- Reset with start held high, then keep start high → stays in IDLE. Release start, then raise it → busy=1, pat_req=1 next cycle, lives=3.
- Accept a pattern, then press btn=0000101 on the 3rd SHOW cycle → score=1, mole=0 next cycle, pat_req after 4 GAP cycles. Hold btn 10 more cycles → pat_req delayed until btn==0.
- Four consecutive hits → level steps 0→1→2 and num_lit 1→2→3. Without input, SHOW then lasts 15 cycles and then 10 cycles.
- With no input, three timeouts (20 cycles each at level 0) → lives 3→2→1→0, game_over=1, hiscore=0.
- btn=0000111 in SHOW → wrong press, lives-1, score unchanged. pat_in=0 for 3 cycles, then valid → stays in REQ, then accepts.
- Game ends with score=2, then next game ends with score=1 → hiscore=2. Pull ena low → hiscore still 2. Pull rst_n low → hiscore 0.

Source files
------------

// File: rtl/mole_round_sched.sv
// mole_round_sched: game-session sequencer for the whack-a-mole datapath.
// Requests patterns, times rounds, judges buttons, tracks score/lives/level.
module mole_round_sched #(
   parameter int ROUND_T0   = 5000,
   parameter int ROUND_STEP = 1000,
   parameter int ROUND_MIN  = 2000,
   parameter int LIVES      = 3,
   parameter int LEVEL_UP   = 5,
   parameter int GAP_CYC    = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   input  logic [6:0] btn,
   output logic       pat_req,
   input  logic       pat_valid,
   input  logic [6:0] pat_in,
   output logic [6:0] mole,
   output logic [1:0] level,
   output logic [2:0] num_lit,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic [7:0] hiscore,
   output logic       game_over,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, REQ, SHOW, GAP, OVER} state_t;

   localparam logic [15:0] T0     = 16'(ROUND_T0);
   localparam logic [15:0] STEP   = 16'(ROUND_STEP);
   localparam logic [15:0] TMIN   = 16'(ROUND_MIN);
   localparam logic [15:0] GAP_M1 = 16'(GAP_CYC - 1);
   localparam logic [1:0]  LIVES2 = 2'(LIVES);
   localparam logic [7:0]  LVL_UP = 8'(LEVEL_UP);

   state_t      state_q;
   logic [6:0]  mole_q;
   logic [1:0]  level_q;
   logic [2:0]  num_lit_q;
   logic [7:0]  score_q;
   logic [1:0]  lives_q;
   logic [7:0]  hiscore_q;
   logic [7:0]  hit_cnt_q;
   logic [15:0] cnt_q;
   logic        pat_req_q;
   logic        game_over_q;
   logic        busy_q;
   logic        start_q;

   logic [15:0] step_d;
   logic [15:0] preset_d;
   logic [7:0]  hit_cnt_d;
   logic        start_edge;
   logic        wrong;
   logic        hit;
   logic        lose;

   // Round length shrinks per level but never underflows or drops below TMIN
   always_comb begin
      step_d   = {14'd0, level_q} * STEP;
      preset_d = TMIN;
      if (T0 >= step_d && (T0 - step_d) > TMIN)
         preset_d = T0 - step_d;
   end

   assign hit_cnt_d  = hit_cnt_q + 8'd1;
   assign start_edge = start & ~start_q;
   assign wrong      = |(btn & ~mole_q);
   assign hit        = (btn & mole_q) == mole_q;
   assign lose       = wrong | (~hit & (cnt_q == 16'd0));

   always_ff @(posedge clk) begin
      if (!rst_n || !ena) begin
         state_q     <= IDLE;
         mole_q      <= '0;
         level_q     <= '0;
         num_lit_q   <= 3'd1;
         score_q     <= '0;
         lives_q     <= '0;
         hit_cnt_q   <= '0;
         cnt_q       <= '0;
         pat_req_q   <= 1'b0;
         game_over_q <= 1'b0;
         busy_q      <= 1'b0;
         start_q     <= 1'b1;
         if (!rst_n)
            hiscore_q <= '0;
      end else begin
         start_q <= start;
         unique case (state_q)
            IDLE, OVER: begin
               if (start_edge) begin
                  score_q     <= '0;
                  lives_q     <= LIVES2;
                  level_q     <= '0;
                  num_lit_q   <= 3'd1;
                  hit_cnt_q   <= '0;
                  state_q     <= REQ;
                  pat_req_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  game_over_q <= 1'b0;
               end
            end
            REQ: begin
               if (pat_valid && pat_in != 7'd0) begin
                  mole_q    <= pat_in;
                  cnt_q     <= preset_d - 16'd1;
                  pat_req_q <= 1'b0;
                  state_q   <= SHOW;
               end
            end
            SHOW: begin
               if (lose) begin
                  mole_q <= '0;
                  if (lives_q == 2'd1) begin
                     lives_q     <= '0;
                     state_q     <= OVER;
                     busy_q      <= 1'b0;
                     game_over_q <= 1'b1;
                     if (score_q > hiscore_q)
                        hiscore_q <= score_q;
                  end else begin
                     lives_q <= lives_q - 2'd1;
                     state_q <= GAP;
                     cnt_q   <= GAP_M1;
                  end
               end else if (hit) begin
                  mole_q  <= '0;
                  state_q <= GAP;
                  cnt_q   <= GAP_M1;
                  if (score_q != 8'hFF)
                     score_q <= score_q + 8'd1;
                  if (hit_cnt_d >= LVL_UP) begin
                     if (level_q != 2'd3) begin
                        level_q   <= level_q + 2'd1;
                        num_lit_q <= num_lit_q + 3'd1;
                        hit_cnt_q <= '0;
                     end else begin
                        hit_cnt_q <= LVL_UP;
                     end
                  end else begin
                     hit_cnt_q <= hit_cnt_d;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            GAP: begin
               if (cnt_q != 16'd0) begin
                  cnt_q <= cnt_q - 16'd1;
               end else if (btn == 7'd0) begin
                  state_q   <= REQ;
                  pat_req_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pat_req   = pat_req_q;
   assign mole      = mole_q;
   assign level     = level_q;
   assign num_lit   = num_lit_q;
   assign score     = score_q;
   assign lives     = lives_q;
   assign hiscore   = hiscore_q;
   assign game_over = game_over_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mole_round_sched.sv
// tb_mole_round_sched: directed game scenarios plus random play,
// every cycle checked against a behavioural model of the game rules.
module tb_mole_round_sched;

   localparam int T0   = 20;
   localparam int STEP = 5;
   localparam int TMIN = 10;
   localparam int LIV  = 3;
   localparam int LUP  = 2;
   localparam int GAPC = 4;

   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_SHOW = 2;
   localparam int P_GAP  = 3;
   localparam int P_OVER = 4;

   logic       clk = 1'b0;
   logic       rst_n, ena, start, pat_valid;
   logic [6:0] btn, pat_in;
   logic       pat_req, game_over, busy;
   logic [6:0] mole;
   logic [1:0] level, lives;
   logic [2:0] num_lit;
   logic [7:0] score, hiscore;

   int vecs = 0;
   int miss = 0;

   int         ph, m_level, m_score, m_lives, m_hi, m_hits, m_age;
   logic       m_prev;
   logic [6:0] m_mole;

   mole_round_sched #(
      .ROUND_T0(T0), .ROUND_STEP(STEP), .ROUND_MIN(TMIN),
      .LIVES(LIV), .LEVEL_UP(LUP), .GAP_CYC(GAPC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
      .btn(btn), .pat_req(pat_req), .pat_valid(pat_valid),
      .pat_in(pat_in), .mole(mole), .level(level),
      .num_lit(num_lit), .score(score), .lives(lives),
      .hiscore(hiscore), .game_over(game_over), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int m_preset(input int lv);
      int p;
      p = T0 - lv * STEP;
      return (p < TMIN) ? TMIN : p;
   endfunction

   task automatic m_lose();
      m_mole = '0;
      if (m_lives == 1) begin
         m_lives = 0;
         ph = P_OVER;
         if (m_score > m_hi) m_hi = m_score;
      end else begin
         m_lives--;
         ph = P_GAP;
         m_age = 0;
      end
   endtask

   task automatic m_hit();
      if (m_score < 255) m_score++;
      m_hits++;
      if (m_hits >= LUP && m_level < 3) begin
         m_level++;
         m_hits = 0;
      end
      m_mole = '0;
      ph = P_GAP;
      m_age = 0;
   endtask

   task automatic model_step();
      logic sedge, is_wrong, is_hit;
      if (!rst_n || !ena) begin
         ph = P_IDLE; m_mole = '0; m_level = 0; m_score = 0;
         m_lives = 0; m_hits = 0; m_prev = 1'b1;
         if (!rst_n) m_hi = 0;
         return;
      end
      sedge = start && !m_prev;
      m_prev = start;
      case (ph)
         P_IDLE, P_OVER: if (sedge) begin
            m_score = 0; m_lives = LIV; m_level = 0;
            m_hits = 0; ph = P_REQ;
         end
         P_REQ: if (pat_valid && pat_in != 0) begin
            m_mole = pat_in; m_age = 0; ph = P_SHOW;
         end
         P_SHOW: begin
            m_age++;
            is_wrong = (btn & ~m_mole) != 0;
            is_hit = (btn & m_mole) == m_mole;
            if (is_wrong) m_lose();
            else if (is_hit) m_hit();
            else if (m_age >= m_preset(m_level)) m_lose();
         end
         P_GAP: begin
            m_age++;
            if (m_age >= GAPC && btn == 0) ph = P_REQ;
         end
         default: ph = P_IDLE;
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("mole", mole, m_mole);
      chk("level", level, m_level);
      chk("num_lit", num_lit, m_level + 1);
      chk("score", score, m_score);
      chk("lives", lives, m_lives);
      chk("hiscore", hiscore, m_hi);
      chk("pat_req", pat_req, ph == P_REQ);
      chk("game_over", game_over, ph == P_OVER);
      chk("busy", busy,
          ph == P_REQ || ph == P_SHOW || ph == P_GAP);
   endtask

   task automatic wait_show();
      int k = 0;
      while (mole == 0 && k < 60) begin
         cyc();
         k++;
      end
      chk("show_wait", mole != 0, 1);
   endtask

   task automatic show_len(input int exp);
      int n = 0;
      wait_show();
      btn = '0;
      while (mole != 0 && n < 100) begin
         cyc();
         n++;
      end
      chk("show_len", n, exp);
   endtask

   task automatic do_hit();
      wait_show();
      btn = m_mole;
      cyc();
      btn = '0;
   endtask

   task automatic new_game();
      start = 1'b0;
      cyc();
      start = 1'b1;
      cyc();
   endtask

   initial begin
      rst_n = 0; ena = 1; start = 1; btn = '0;
      pat_valid = 1; pat_in = 7'b0000101;
      ph = P_IDLE; m_hi = 0; m_prev = 1; m_mole = '0;
      m_level = 0; m_score = 0; m_lives = 0; m_hits = 0; m_age = 0;
      cyc(); cyc();
      chk("rst_hiscore", hiscore, 0);
      chk("rst_lives", lives, 0);
      rst_n = 1;
      repeat (3) cyc();
      chk("held_start_idle", busy, 0);

      new_game();
      chk("start_busy", busy, 1);
      chk("start_req", pat_req, 1);
      chk("start_lives", lives, LIV);

      cyc();
      chk("accept_mole", mole, 7'b0000101);
      cyc(); cyc();
      btn = 7'b0000101;
      cyc();
      btn = '0;
      chk("hit_score", score, 1);
      chk("hit_mole", mole, 0);
      repeat (3) begin
         cyc();
         chk("gap_noreq", pat_req, 0);
      end
      cyc();
      chk("gap_req", pat_req, 1);

      cyc();
      btn = 7'b0000101;
      repeat (10) begin
         cyc();
         chk("held_noreq", pat_req, 0);
      end
      btn = '0;
      cyc();
      chk("release_req", pat_req, 1);
      chk("lvl1", level, 1);
      chk("lvl1_lit", num_lit, 2);

      show_len(15);
      chk("to_lives", lives, 2);
      chk("to_level", level, 1);
      do_hit();
      do_hit();
      chk("lvl2", level, 2);
      chk("lvl2_lit", num_lit, 3);
      chk("lvl2_score", score, 4);
      show_len(10);
      chk("to2_lives", lives, 1);

      wait_show();
      btn = 7'b0000111;
      cyc();
      btn = '0;
      chk("over_flag", game_over, 1);
      chk("over_hi", hiscore, 4);
      chk("over_busy", busy, 0);

      pat_in = '0;
      new_game();
      repeat (3) begin
         cyc();
         chk("zero_pat_req", pat_req, 1);
         chk("zero_pat_mole", mole, 0);
      end
      pat_in = 7'b0000101;
      cyc();
      chk("late_accept", mole, 7'b0000101);
      btn = 7'b0000111;
      cyc();
      btn = '0;
      chk("wrong_lives", lives, 2);
      chk("wrong_score", score, 0);
      show_len(20);
      show_len(20);
      chk("to_over", game_over, 1);
      chk("to_hi", hiscore, 4);

      ena = 0;
      cyc(); cyc();
      chk("ena_hi", hiscore, 4);
      chk("ena_over", game_over, 0);
      ena = 1;
      cyc();
      rst_n = 0;
      cyc();
      chk("rstn_hi", hiscore, 0);
      rst_n = 1;

      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(99);
         if (r < 70) btn = '0;
         else if (r < 85) btn = m_mole;
         else if (r < 95) btn = 7'($urandom);
         else btn = m_mole | 7'(1 << $urandom_range(6));
         if ($urandom_range(19) == 0) start = ~start;
         pat_valid = $urandom_range(1);
         pat_in = ($urandom_range(4) == 0) ? 7'd0 : 7'($urandom);
         ena = $urandom_range(199) != 0;
         rst_n = $urandom_range(399) != 0;
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
